// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: register value, grant owner and
// arbiter state encodings.
package memory_arbiter_pkg;

  localparam int REGVAL_W = 32;

  typedef logic [REGVAL_W-1:0] regval_t;

  typedef enum logic [1:0] {
    OwnerNone,
    OwnerFetch,
    OwnerRead,
    OwnerWrite
  } owner_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    DONE
  } state_t;

  function automatic logic owner_is_write(input owner_t owner);
    return owner == OwnerWrite;
  endfunction

endpackage

// File: rtl/memory_arbiter_priority_picker.sv
// Combinational grant selection: write > read > fetch, unless a waiting fetch
// has been passed over often enough to be forced through.
module memory_arbiter_priority_picker
  import memory_arbiter_pkg::*;
(
  input  logic   i_fetch_request,
  input  logic   i_read_request,
  input  logic   i_write_request,
  input  logic   i_starved,
  output owner_t o_winner
);

  always_comb begin
    o_winner = OwnerNone;
    if (i_fetch_request && i_starved) begin
      o_winner = OwnerFetch;
    end else if (i_write_request) begin
      o_winner = OwnerWrite;
    end else if (i_read_request) begin
      o_winner = OwnerRead;
    end else if (i_fetch_request) begin
      o_winner = OwnerFetch;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one external memory port between fetch, data-read and store
// requesters; one transaction in flight, one done pulse per completed grant.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int WIDTH        = $bits(regval_t),
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fetch_request,
  input  logic [WIDTH-1:0] fetch_address,
  output logic             fetch_done,
  output logic [WIDTH-1:0] fetch_data,
  input  logic             read_request,
  input  logic [WIDTH-1:0] read_address,
  output logic             read_done,
  output logic [WIDTH-1:0] read_data,
  input  logic             write_request,
  input  logic [WIDTH-1:0] write_address,
  input  logic [WIDTH-1:0] write_data,
  output logic             write_done,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_writedata,
  input  logic             mem_waitrequest,
  input  logic [WIDTH-1:0] mem_readdata,
  input  logic             mem_readdatavalid
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_t           r_state;
  owner_t           r_owner;
  logic [CW-1:0]    r_starve;
  logic             r_mem_read;
  logic             r_mem_write;
  logic [WIDTH-1:0] r_mem_address;
  logic [WIDTH-1:0] r_mem_writedata;
  logic             r_fetch_done;
  logic             r_read_done;
  logic             r_write_done;
  logic [WIDTH-1:0] r_fetch_data;
  logic [WIDTH-1:0] r_read_data;

  owner_t           w_winner;
  logic             w_starved;
  logic             w_grant;

  assign w_starved = (r_starve == LIMIT);
  assign w_grant   = (r_state == IDLE) && (w_winner != OwnerNone);

  memory_arbiter_priority_picker u_picker (
    .i_fetch_request (fetch_request),
    .i_read_request  (read_request),
    .i_write_request (write_request),
    .i_starved       (w_starved),
    .o_winner        (w_winner)
  );

  // Counts grants that bypassed a waiting fetch; saturates at the limit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_starve <= '0;
    end else if (!fetch_request) begin
      r_starve <= '0;
    end else if (w_grant) begin
      if (w_winner == OwnerFetch) begin
        r_starve <= '0;
      end else if (!w_starved) begin
        r_starve <= r_starve + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_owner         <= OwnerNone;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_address   <= '0;
      r_mem_writedata <= '0;
      r_fetch_done    <= 1'b0;
      r_read_done     <= 1'b0;
      r_write_done    <= 1'b0;
      r_fetch_data    <= '0;
      r_read_data     <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_owner <= w_winner;
          case (w_winner)
            OwnerWrite: begin
              r_mem_write     <= 1'b1;
              r_mem_address   <= write_address;
              r_mem_writedata <= write_data;
              r_state         <= ISSUE;
            end
            OwnerRead: begin
              r_mem_read    <= 1'b1;
              r_mem_address <= read_address;
              r_state       <= ISSUE;
            end
            OwnerFetch: begin
              r_mem_read    <= 1'b1;
              r_mem_address <= fetch_address;
              r_state       <= ISSUE;
            end
            default: r_state <= IDLE;
          endcase
        end

        ISSUE: begin
          if (!mem_waitrequest) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (owner_is_write(r_owner)) begin
              r_write_done <= 1'b1;
              r_state      <= DONE;
            end else begin
              r_state <= WAIT_DATA;
            end
          end
        end

        WAIT_DATA: begin
          if (mem_readdatavalid) begin
            if (r_owner == OwnerFetch) begin
              r_fetch_data <= mem_readdata;
              r_fetch_done <= 1'b1;
            end else begin
              r_read_data <= mem_readdata;
              r_read_done <= 1'b1;
            end
            r_state <= DONE;
          end
        end

        DONE: begin
          r_fetch_done <= 1'b0;
          r_read_done  <= 1'b0;
          r_write_done <= 1'b0;
          r_owner      <= OwnerNone;
          r_state      <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign mem_address   = r_mem_address;
  assign mem_writedata = r_mem_writedata;
  assign fetch_done    = r_fetch_done;
  assign read_done     = r_read_done;
  assign write_done    = r_write_done;
  assign fetch_data    = r_fetch_data;
  assign read_data     = r_read_data;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: transaction-level reference model, behavioural
// memory responder and requesters driven on the falling clock edge.
module tb_memory_arbiter;

  localparam int W     = 32;
  localparam int LIMIT = 4;

  logic          clock;
  logic          reset;
  logic          fetch_request;
  logic [W-1:0]  fetch_address;
  logic          fetch_done;
  logic [W-1:0]  fetch_data;
  logic          read_request;
  logic [W-1:0]  read_address;
  logic          read_done;
  logic [W-1:0]  read_data;
  logic          write_request;
  logic [W-1:0]  write_address;
  logic [W-1:0]  write_data;
  logic          write_done;
  logic          mem_read;
  logic          mem_write;
  logic [W-1:0]  mem_address;
  logic [W-1:0]  mem_writedata;
  logic          mem_waitrequest;
  logic [W-1:0]  mem_readdata;
  logic          mem_readdatavalid;

  memory_arbiter #(.WIDTH(W), .STARVE_LIMIT(LIMIT)) dut (
    .clock             (clock),
    .reset             (reset),
    .fetch_request     (fetch_request),
    .fetch_address     (fetch_address),
    .fetch_done        (fetch_done),
    .fetch_data        (fetch_data),
    .read_request      (read_request),
    .read_address      (read_address),
    .read_done         (read_done),
    .read_data         (read_data),
    .write_request     (write_request),
    .write_address     (write_address),
    .write_data        (write_data),
    .write_done        (write_done),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_address       (mem_address),
    .mem_writedata     (mem_writedata),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Requester ids: 0 fetch, 1 read, 2 write.
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;

  int          m_owner;
  bit          m_busy, m_release, m_issuing, done_due;
  int          m_starve;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] exp_fetch_data, exp_read_data, pend_data;
  int          wait_left, pend_cnt, m_lat, cfg_wait, cfg_lat;
  bit          rand_cfg, spurious;
  logic [31:0] mem_model [logic [31:0]];
  int          re_prob[3];
  int          raise_prob[3];
  int          done_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_busy = 0; m_release = 0; m_issuing = 0; done_due = 0;
    m_starve = 0; pend_cnt = 0; wait_left = 0; spurious = 0;
    exp_fetch_data = '0; exp_read_data = '0;
  endtask

  task automatic raise(input int i);
    logic [31:0] a;
    a = $urandom & 32'h0000_03FC;
    case (i)
      0: begin fetch_address = a; fetch_request = 1'b1; end
      1: begin read_address = a; read_request = 1'b1; end
      default: begin write_address = a; write_data = $urandom; write_request = 1'b1; end
    endcase
  endtask

  task automatic drop(input int i);
    case (i)
      0: fetch_request = 1'b0;
      1: read_request = 1'b0;
      default: write_request = 1'b0;
    endcase
  endtask

  // Reference for the clock edge ahead, using the inputs now driven.
  task automatic model_edge();
    if (!fetch_request) m_starve = 0;
    if (!m_busy) begin
      if (fetch_request || read_request || write_request) begin
        if (fetch_request && m_starve == LIMIT) m_owner = 0;
        else if (write_request) m_owner = 2;
        else if (read_request) m_owner = 1;
        else m_owner = 0;
        if (fetch_request)
          m_starve = (m_owner == 0) ? 0 : ((m_starve < LIMIT) ? m_starve + 1 : LIMIT);
        case (m_owner)
          0: m_addr = fetch_address;
          1: m_addr = read_address;
          default: begin m_addr = write_address; m_wdata = write_data; end
        endcase
        m_busy    = 1;
        m_issuing = 1;
        wait_left = rand_cfg ? int'($urandom_range(3, 0)) : cfg_wait;
        m_lat     = rand_cfg ? int'($urandom_range(4, 1)) : cfg_lat;
      end
    end else if (m_release) begin
      m_busy    = 0;
      m_release = 0;
    end
  endtask

  task automatic step();
    logic [2:0] obs_done, exp_done;
    model_edge();
    @(negedge clock);
    cyc++;
    obs_done = {write_done, read_done, fetch_done};
    exp_done = done_due ? (3'b001 << m_owner) : 3'b000;
    chk("done_pulses", 32'(obs_done), 32'(exp_done));
    chk("mem_read", 32'(mem_read), 32'(m_issuing && m_owner != 2));
    chk("mem_write", 32'(mem_write), 32'(m_issuing && m_owner == 2));
    chk("one_strobe", 32'(mem_read & mem_write), 32'(0));
    if (m_issuing) begin
      chk("mem_address", mem_address, m_addr);
      if (m_owner == 2) chk("mem_writedata", mem_writedata, m_wdata);
    end
    chk("fetch_data", fetch_data, exp_fetch_data);
    chk("read_data", read_data, exp_read_data);
    for (int i = 0; i < 3; i++) if (obs_done[i]) done_log.push_back(i);
    if (done_due) m_release = 1;
    done_due = 0;

    mem_readdatavalid = 1'b0;
    mem_readdata      = $urandom;
    if (spurious) begin
      mem_readdatavalid = 1'b1;
      mem_readdata      = '1;
      spurious          = 0;
    end
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mem_readdatavalid = 1'b1;
        mem_readdata      = pend_data;
        done_due          = 1;
        if (m_owner == 0) exp_fetch_data = pend_data;
        else exp_read_data = pend_data;
      end
    end
    if (m_issuing) begin
      if (wait_left > 0) begin
        mem_waitrequest = 1'b1;
        wait_left--;
      end else begin
        mem_waitrequest = 1'b0;
        m_issuing       = 0;
        if (m_owner == 2) begin
          mem_model[m_addr] = m_wdata;
          done_due = 1;
        end else begin
          pend_cnt  = m_lat;
          pend_data = mem_rd(m_addr);
        end
      end
    end else begin
      mem_waitrequest = 1'($urandom_range(1, 0));
    end

    for (int i = 0; i < 3; i++) begin
      logic active;
      active = (i == 0) ? fetch_request : (i == 1) ? read_request : write_request;
      if (obs_done[i]) begin
        if (int'($urandom_range(99, 0)) < re_prob[i]) raise(i);
        else drop(i);
      end else if (!active && int'($urandom_range(99, 0)) < raise_prob[i]) begin
        raise(i);
      end
    end
  endtask

  task automatic run_until_dones(input int n, input int budget, input string tag);
    int start, k;
    start = done_log.size();
    k = 0;
    while (done_log.size() < start + n && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(done_log.size() - start), 32'(n));
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((fetch_request || read_request || write_request || m_busy) && k < budget) begin
      step();
      k++;
    end
    chk("drain_idle", 32'(fetch_request || read_request || write_request || m_busy), 32'(0));
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_strobes"}, 32'({mem_read, mem_write}), 32'(0));
    chk({tag, "_dones"}, 32'({fetch_done, read_done, write_done}), 32'(0));
    chk({tag, "_mem_address"}, mem_address, 32'(0));
    chk({tag, "_mem_writedata"}, mem_writedata, 32'(0));
    chk({tag, "_fetch_data"}, fetch_data, 32'(0));
    chk({tag, "_read_data"}, read_data, 32'(0));
  endtask

  initial begin
    int lg, strobes, dones;
    int exp_seq[10];
    logic [31:0] saved_f, saved_r;

    reset = 1'b1;
    fetch_request = 1'b0; read_request = 1'b0; write_request = 1'b0;
    fetch_address = '0; read_address = '0; write_address = '0; write_data = '0;
    mem_waitrequest = 1'b0; mem_readdata = '0; mem_readdatavalid = 1'b0;
    for (int i = 0; i < 3; i++) begin re_prob[i] = 0; raise_prob[i] = 0; end
    rand_cfg = 0; cfg_wait = 0; cfg_lat = 1;
    model_reset();

    step();
    step();
    reset_chk("reset");
    reset = 1'b0;
    step();

    // Single write, no wait states.
    write_address = 32'h100; write_data = 32'hDEADBEEF; write_request = 1'b1;
    step();
    chk("wr_c1_strobe", 32'(mem_write), 32'(1));
    chk("wr_c1_addr", mem_address, 32'h100);
    chk("wr_c1_data", mem_writedata, 32'hDEADBEEF);
    step();
    chk("wr_c2_done", 32'(write_done), 32'(1));
    drain(20);

    // Read with three wait states and data two cycles after acceptance.
    mem_model[32'h40] = 32'h12345678;
    cfg_wait = 3; cfg_lat = 2;
    read_address = 32'h40; read_request = 1'b1;
    strobes = 0; dones = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (mem_read) strobes++;
      if (read_done) dones++;
    end
    chk("rd_strobe_cycles", 32'(strobes), 32'(4));
    chk("rd_done_count", 32'(dones), 32'(1));
    chk("rd_data", read_data, 32'h12345678);

    // All three at once.
    cfg_wait = 1; cfg_lat = 1;
    fetch_address = 32'h200; read_address = 32'h204;
    write_address = 32'h208; write_data = 32'h0BAD_F00D;
    fetch_request = 1'b1; read_request = 1'b1; write_request = 1'b1;
    lg = done_log.size();
    run_until_dones(3, 80, "all3_dones");
    if (done_log.size() >= lg + 3) begin
      chk("all3_first", 32'(done_log[lg]), 32'(2));
      chk("all3_second", 32'(done_log[lg + 1]), 32'(1));
      chk("all3_third", 32'(done_log[lg + 2]), 32'(0));
    end
    drain(20);

    // Starvation: write keeps re-requesting, fetch forced through every 5th grant.
    cfg_wait = 0; cfg_lat = 1;
    re_prob[0] = 100; re_prob[1] = 100; re_prob[2] = 100;
    raise(0); raise(1); raise(2);
    exp_seq = '{2, 2, 2, 2, 0, 2, 2, 2, 2, 0};
    lg = done_log.size();
    run_until_dones(10, 200, "starve_dones");
    if (done_log.size() >= lg + 10)
      for (int i = 0; i < 10; i++) chk($sformatf("starve_grant%0d", i), 32'(done_log[lg + i]), 32'(exp_seq[i]));
    re_prob[0] = 0; re_prob[1] = 0; re_prob[2] = 0;
    drain(100);

    // Spurious readdatavalid while idle.
    saved_f = exp_fetch_data; saved_r = exp_read_data;
    spurious = 1;
    step();
    step();
    step();
    chk("spur_fetch_data", fetch_data, saved_f);
    chk("spur_read_data", read_data, saved_r);
    chk("spur_no_done", 32'({fetch_done, read_done, write_done}), 32'(0));

    // Reset asserted while a read waits for data.
    cfg_wait = 0; cfg_lat = 4;
    read_address = 32'h80; read_request = 1'b1;
    for (int i = 0; i < 10 && !(m_busy && !m_issuing && pend_cnt > 0); i++) step();
    chk("rst_reached_wait", 32'(m_busy && !m_issuing && pend_cnt > 0), 32'(1));
    step();
    reset = 1'b1;
    #1;
    reset_chk("midreset");
    read_request = 1'b0;
    mem_readdatavalid = 1'b0;
    model_reset();
    step();
    step();
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (read_done) dones++;
    end
    chk("midreset_no_read_done", 32'(dones), 32'(0));
    mem_model[32'h0] = 32'hCAFEF00D;
    cfg_lat = 1;
    fetch_address = 32'h0; fetch_request = 1'b1;
    run_until_dones(1, 30, "post_reset_fetch");
    chk("post_reset_fetch_data", fetch_data, 32'hCAFEF00D);
    if (done_log.size() > 0) chk("post_reset_owner", 32'(done_log[done_log.size() - 1]), 32'(0));
    drain(20);

    // Randomized traffic against the reference model.
    rand_cfg = 1;
    for (int i = 0; i < 3; i++) begin re_prob[i] = 50; raise_prob[i] = 20; end
    for (int i = 0; i < 2000; i++) step();
    for (int i = 0; i < 3; i++) begin re_prob[i] = 0; raise_prob[i] = 0; end
    drain(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
